// File: rtl/captura_campos_vga_pkg.sv
// rtl/captura_campos_vga_pkg.sv - field codes, scan length and FSM encoding
package captura_campos_vga_pkg;

  localparam int CAMPO_DIA      = 0;
  localparam int CAMPO_MES      = 1;
  localparam int CAMPO_ANO      = 2;
  localparam int CAMPO_HORA     = 3;
  localparam int CAMPO_MIN      = 4;
  localparam int CAMPO_SEG      = 5;
  localparam int CAMPO_THORA    = 6;
  localparam int CAMPO_TMIN     = 7;
  localparam int CAMPO_TSEG     = 8;
  localparam int NUM_CAMPOS_DEF = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PUBLICA = 2'd2
  } estado_t;

endpackage

// File: rtl/captura_campos_vga_validador_bcd.sv
// rtl/captura_campos_vga_validador_bcd.sv - combinational two-digit BCD validity check
module validador_bcd (
  input  logic [7:0] valor,
  output logic       valido
);

  assign valido = (valor[7:4] <= 4'd9) && (valor[3:0] <= 4'd9);

endmodule

// File: rtl/captura_campos_vga.sv
// rtl/captura_campos_vga.sv - per-frame RTC field scanner with double-buffered publish
module captura_campos_vga
  import captura_campos_vga_pkg::*;
#(
  parameter int NUM_CAMPOS = NUM_CAMPOS_DEF,
  parameter int SETTLE     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [7:0] dato,
  input  logic       am,
  output logic [3:0] seleccion_dato,
  output logic [7:0] d_disp,
  output logic [7:0] me_disp,
  output logic [7:0] a_disp,
  output logic [7:0] h_disp,
  output logic [7:0] m_disp,
  output logic [7:0] s_disp,
  output logic [7:0] ht_disp,
  output logic [7:0] mt_disp,
  output logic [7:0] st_disp,
  output logic       am_disp,
  output logic [8:0] err_bcd,
  output logic       ocupado,
  output logic       captura_lista,
  output logic       sobrecarga
);

  estado_t estado, estado_sig;

  logic [3:0] idx;
  logic [2:0] cnt;
  logic       dato_ok;
  logic       arrancar, muestrear, ultimo, publicar;

  logic [7:0]                shadow     [NUM_CAMPOS_DEF];
  logic [NUM_CAMPOS_DEF-1:0] err_shadow;
  logic                      am_shadow;
  logic [7:0]                pub        [NUM_CAMPOS_DEF];
  logic [NUM_CAMPOS_DEF-1:0] err_pub;
  logic                      am_pub;

  validador_bcd u_validador (
    .valor  (dato),
    .valido (dato_ok)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= IDLE;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:    if (frame_start) estado_sig = SCAN;
      SCAN:    if (ultimo)      estado_sig = PUBLICA;
      PUBLICA: estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  always_comb begin
    arrancar  = (estado == IDLE) && frame_start;
    muestrear = (estado == SCAN) && (cnt == 3'd0);
    ultimo    = muestrear && (idx == 4'(NUM_CAMPOS - 1));
    publicar  = (estado == PUBLICA);
  end

  // idx doubles as the registered mux select; it parks at 0 outside a scan
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      cnt        <= '0;
      err_shadow <= '0;
      am_shadow  <= 1'b1;
      for (int i = 0; i < NUM_CAMPOS_DEF; i++) shadow[i] <= '0;
    end else if (arrancar) begin
      idx <= '0;
      cnt <= 3'(SETTLE);
    end else if (estado == SCAN) begin
      if (!muestrear) begin
        cnt <= cnt - 3'd1;
      end else begin
        // an invalid code keeps the value on screen rather than showing garbage
        shadow[idx]     <= dato_ok ? dato : pub[idx];
        err_shadow[idx] <= !dato_ok;
        if (idx == 4'(CAMPO_HORA)) am_shadow <= am;
        idx <= ultimo ? 4'd0 : idx + 4'd1;
        cnt <= 3'(SETTLE);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_pub       <= '0;
      am_pub        <= 1'b1;
      ocupado       <= 1'b0;
      captura_lista <= 1'b0;
      sobrecarga    <= 1'b0;
      for (int i = 0; i < NUM_CAMPOS_DEF; i++) pub[i] <= '0;
    end else begin
      captura_lista <= publicar;
      if (frame_start && (estado != IDLE)) sobrecarga <= 1'b1;
      if (arrancar)      ocupado <= 1'b1;
      else if (publicar) ocupado <= 1'b0;
      if (publicar) begin
        pub     <= shadow;
        err_pub <= err_shadow;
        am_pub  <= am_shadow;
      end
    end
  end

  assign seleccion_dato = idx;
  assign d_disp         = pub[CAMPO_DIA];
  assign me_disp        = pub[CAMPO_MES];
  assign a_disp         = pub[CAMPO_ANO];
  assign h_disp         = pub[CAMPO_HORA];
  assign m_disp         = pub[CAMPO_MIN];
  assign s_disp         = pub[CAMPO_SEG];
  assign ht_disp        = pub[CAMPO_THORA];
  assign mt_disp        = pub[CAMPO_TMIN];
  assign st_disp        = pub[CAMPO_TSEG];
  assign am_disp        = am_pub;
  assign err_bcd        = err_pub;

endmodule

// File: tb/tb_captura_campos_vga.sv
// tb/tb_captura_campos_vga.sv - randomized bench for captura_campos_vga, SETTLE=1 and SETTLE=0 builds
module tb_captura_campos_vga;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fs      [2];
  logic [7:0] dato    [2];
  logic       am_in   [2];
  logic [3:0] sel     [2];
  logic [7:0] disp    [2][9];
  logic       am_d    [2];
  logic [8:0] err     [2];
  logic       ocup    [2];
  logic       lista   [2];
  logic       sobre   [2];

  logic [7:0] tabla [16];
  logic       am_val;

  logic [7:0] exp_pub  [2][9];
  logic [8:0] exp_err  [2];
  logic       exp_am   [2];
  logic       exp_sobre[2];

  int total = 0;
  int pasadas = 0;

  always #5 clk = ~clk;

  assign dato[0]  = tabla[sel[0]];
  assign dato[1]  = tabla[sel[1]];
  assign am_in[0] = (sel[0] == 4'd3) ? am_val : ~am_val;
  assign am_in[1] = (sel[1] == 4'd3) ? am_val : ~am_val;

  captura_campos_vga #(.SETTLE(0)) dut0 (
    .clk(clk), .reset(rst_n), .frame_start(fs[0]), .dato(dato[0]), .am(am_in[0]),
    .seleccion_dato(sel[0]),
    .d_disp(disp[0][0]), .me_disp(disp[0][1]), .a_disp(disp[0][2]), .h_disp(disp[0][3]),
    .m_disp(disp[0][4]), .s_disp(disp[0][5]), .ht_disp(disp[0][6]), .mt_disp(disp[0][7]),
    .st_disp(disp[0][8]), .am_disp(am_d[0]), .err_bcd(err[0]), .ocupado(ocup[0]),
    .captura_lista(lista[0]), .sobrecarga(sobre[0])
  );

  captura_campos_vga #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(rst_n), .frame_start(fs[1]), .dato(dato[1]), .am(am_in[1]),
    .seleccion_dato(sel[1]),
    .d_disp(disp[1][0]), .me_disp(disp[1][1]), .a_disp(disp[1][2]), .h_disp(disp[1][3]),
    .m_disp(disp[1][4]), .s_disp(disp[1][5]), .ht_disp(disp[1][6]), .mt_disp(disp[1][7]),
    .st_disp(disp[1][8]), .am_disp(am_d[1]), .err_bcd(err[1]), .ocupado(ocup[1]),
    .captura_lista(lista[1]), .sobrecarga(sobre[1])
  );

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs === esp) pasadas++;
    else $display("FAIL %s: obtenido %0h esperado %0h", tag, obs, esp);
  endtask

  task automatic modelo_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 9; i++) exp_pub[d][i] = 8'h00;
      exp_err[d]   = '0;
      exp_am[d]    = 1'b1;
      exp_sobre[d] = 1'b0;
    end
  endtask

  // A field is a pair of decimal digits; anything else keeps the old value and raises its flag
  task automatic modelo_publica(input int d);
    for (int i = 0; i < 9; i++) begin
      if (tabla[i] / 16 < 10 && tabla[i] % 16 < 10) begin
        exp_pub[d][i] = tabla[i];
        exp_err[d][i] = 1'b0;
      end else begin
        exp_err[d][i] = 1'b1;
      end
    end
    exp_am[d] = am_val;
  endtask

  task automatic comprobar_salidas(input int d, input string pre);
    for (int i = 0; i < 9; i++)
      comprobar($sformatf("%s_d%0d_campo%0d", pre, d, i), 32'(disp[d][i]), 32'(exp_pub[d][i]));
    comprobar($sformatf("%s_d%0d_err", pre, d), 32'(err[d]), 32'(exp_err[d]));
    comprobar($sformatf("%s_d%0d_am", pre, d), 32'(am_d[d]), 32'(exp_am[d]));
    comprobar($sformatf("%s_d%0d_sobre", pre, d), 32'(sobre[d]), 32'(exp_sobre[d]));
    comprobar($sformatf("%s_d%0d_ocupado", pre, d), 32'(ocup[d]), 32'(0));
  endtask

  // Pulses frame_start and watches one whole scan; repulso >= 0 re-pulses at that cycle offset
  task automatic escanear(input int d, input int repulso, input string pre);
    int periodo, esp_lat, primera, pulsos, err_sel, err_estable;
    logic [7:0] previo [9];
    periodo = d + 1;
    esp_lat = 9 * periodo + 1;
    primera = -1; pulsos = 0; err_sel = 0; err_estable = 0;
    for (int i = 0; i < 9; i++) previo[i] = disp[d][i];
    fs[d] = 1'b1;
    @(posedge clk); #1;
    fs[d] = 1'b0;
    for (int k = 0; k <= esp_lat + 4; k++) begin
      if (k < 9 * periodo && sel[d] !== 4'(k / periodo)) err_sel++;
      if (k < esp_lat)
        for (int i = 0; i < 9; i++) if (disp[d][i] !== previo[i]) err_estable++;
      if (lista[d] === 1'b1) begin
        pulsos++;
        if (primera < 0) primera = k;
      end
      fs[d] = (k + 1 == repulso);
      @(posedge clk); #1;
    end
    fs[d] = 1'b0;
    if (repulso >= 0) exp_sobre[d] = 1'b1;
    modelo_publica(d);
    comprobar($sformatf("%s_d%0d_latencia", pre, d), 32'(primera), 32'(esp_lat));
    comprobar($sformatf("%s_d%0d_pulsos", pre, d), 32'(pulsos), 32'(1));
    comprobar($sformatf("%s_d%0d_sel_pasos", pre, d), 32'(err_sel), 32'(0));
    comprobar($sformatf("%s_d%0d_estable", pre, d), 32'(err_estable), 32'(0));
    comprobar_salidas(d, pre);
  endtask

  task automatic tabla_aleatoria();
    for (int i = 0; i < 9; i++) begin
      if ($urandom_range(0, 3) == 0) tabla[i] = 8'($urandom);
      else tabla[i] = 8'({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
    end
    am_val = 1'($urandom);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) tabla[i] = 8'h00;
    am_val = 1'b1;
    fs[0] = 1'b0; fs[1] = 1'b0;
    rst_n = 1'b0;
    modelo_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (lista[0] === 1'b1 || lista[1] === 1'b1) n++;
    end
    comprobar("reposo_lista", 32'(n), 32'(0));
    comprobar("reposo_sel", 32'({sel[1], sel[0]}), 32'(0));
    comprobar_salidas(1, "reposo");
    comprobar_salidas(0, "reposo");

    tabla[0] = 8'h15; tabla[1] = 8'h06; tabla[2] = 8'h16; tabla[3] = 8'h11;
    tabla[4] = 8'h42; tabla[5] = 8'h07; tabla[6] = 8'h05; tabla[7] = 8'h17;
    tabla[8] = 8'h52; am_val = 1'b0;
    escanear(1, -1, "directo");

    repeat (3) @(posedge clk); #1;
    tabla[4] = 8'h4A; tabla[0] = 8'h28; tabla[8] = 8'h33;
    escanear(1, -1, "bcd_malo");
    comprobar("bcd_malo_m", 32'(disp[1][4]), 32'h42);
    comprobar("bcd_malo_err", 32'(err[1]), 32'h010);

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk); #1;
      tabla_aleatoria();
      escanear(1, -1, $sformatf("azar%0d", r));
    end

    tabla_aleatoria();
    escanear(1, 5, "sobrecarga");
    tabla_aleatoria();
    escanear(1, -1, "sobre_pegajosa");

    tabla_aleatoria();
    fs[1] = 1'b1;
    @(posedge clk); #1;
    fs[1] = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    modelo_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (lista[1] === 1'b1) n++;
    end
    comprobar("abortado_lista", 32'(n), 32'(0));
    comprobar_salidas(1, "abortado");
    escanear(1, -1, "tras_reset");

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk); #1;
      tabla_aleatoria();
      escanear(0, -1, $sformatf("settle0_%0d", r));
    end
    tabla_aleatoria();
    escanear(0, 10, "settle0_borde_publica");

    $display("%0d/%0d checks passed", pasadas, total);
    $finish;
  end

endmodule
